// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: built-in self-test that sweeps every (A, B) operand
// pair, checks both De Morgan identities bitwise through a one-stage pipeline
// and accumulates a mismatch count, the first failing vector and a pass flag.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; aborts and clears everything
//   start          single-cycle request, honoured in IDLE or DONE
//   inject0        XOR fault mask on the ~(A|B) term, latched at start
//   inject1        XOR fault mask on the ~(A&B) term, latched at start
//   busy           high in RUN and DRAIN
//   done           high in DONE until the next accepted start or reset
//   pass           done with zero failures
//   err_count      total identity failures (up to 2N, never wraps)
//   first_fail_a   A of the first failing vector
//   first_fail_b   B of the first failing vector
//   first_fail_id  {identity1 failed, identity0 failed} for that vector
//   cur_a, cur_b   vector currently issued
module demorgan_sweep_checker #(
    parameter int unsigned WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     inject0,
    input  logic [WIDTH-1:0]     inject1,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic [1:0]           first_fail_id,
    output logic [WIDTH-1:0]     cur_a,
    output logic [WIDTH-1:0]     cur_b
);

    localparam int unsigned CW = 2 * WIDTH;
    localparam int unsigned EW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] inj0_q;
    logic [WIDTH-1:0] inj1_q;

    // Pipeline stage P: fail bits and operands of the previously issued vector
    logic             p_valid;
    logic [1:0]       p_fail;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;

    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic             id0_fail;
    logic             id1_fail;
    logic [EW-1:0]    acc_inc;
    logic [EW-1:0]    err_next;
    logic             load_first;
    logic             cnt_last;

    // Identity evaluation for the issued vector and accumulation of stage P
    always_comb begin
        vec_a      = cnt[CW-1:WIDTH];
        vec_b      = cnt[WIDTH-1:0];
        id0_fail   = |((~vec_a & ~vec_b) ^ (~(vec_a | vec_b) ^ inj0_q));
        id1_fail   = |((~vec_a | ~vec_b) ^ (~(vec_a & vec_b) ^ inj1_q));
        acc_inc    = '0;
        if (p_valid) begin
            acc_inc = EW'(p_fail[0]) + EW'(p_fail[1]);
        end
        err_next   = err_count + acc_inc;
        // first_fail_id is nonzero exactly once a failure has been recorded
        load_first = p_valid && (p_fail != 2'b00) && (first_fail_id == 2'b00);
        cnt_last   = (cnt == {CW{1'b1}});
    end

    assign cur_a = vec_a;
    assign cur_b = vec_b;

    // Sweep FSM, pipeline stage and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            inj0_q        <= '0;
            inj1_q        <= '0;
            p_valid       <= 1'b0;
            p_fail        <= 2'b00;
            p_a           <= '0;
            p_b           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_fail_a  <= '0;
            first_fail_b  <= '0;
            first_fail_id <= 2'b00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        cnt           <= '0;
                        inj0_q        <= inject0;
                        inj1_q        <= inject1;
                        p_valid       <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_fail_a  <= '0;
                        first_fail_b  <= '0;
                        first_fail_id <= 2'b00;
                    end
                end
                RUN: begin
                    p_valid   <= 1'b1;
                    p_fail    <= {id1_fail, id0_fail};
                    p_a       <= vec_a;
                    p_b       <= vec_b;
                    err_count <= err_next;
                    if (load_first) begin
                        first_fail_a  <= p_a;
                        first_fail_b  <= p_b;
                        first_fail_id <= p_fail;
                    end
                    // Last vector stays on cur_a/cur_b while draining
                    if (cnt_last) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    p_valid   <= 1'b0;
                    err_count <= err_next;
                    if (load_first) begin
                        first_fail_a  <= p_a;
                        first_fail_b  <= p_b;
                        first_fail_id <= p_fail;
                    end
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// tb_demorgan_sweep_checker: directed sweeps of a WIDTH=2 and a WIDTH=1
// checker with hand-computed results, fault masks, ignored mid-run starts,
// restart from DONE and an asynchronous mid-sweep reset.
module tb_demorgan_sweep_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    // WIDTH=2 instance
    logic       start = 1'b0;
    logic [1:0] inject0 = 2'b00;
    logic [1:0] inject1 = 2'b00;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic [1:0] first_fail_a, first_fail_b, first_fail_id;
    logic [1:0] cur_a, cur_b;

    // WIDTH=1 instance
    logic       start_w1 = 1'b0;
    logic       inject0_w1 = 1'b0;
    logic       inject1_w1 = 1'b0;
    logic       busy_w1, done_w1, pass_w1;
    logic [3:0] err_count_w1;
    logic       first_fail_a_w1, first_fail_b_w1;
    logic [1:0] first_fail_id_w1;
    logic       cur_a_w1, cur_b_w1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demorgan_sweep_checker #(.WIDTH(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .inject0(inject0), .inject1(inject1),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
        .first_fail_id(first_fail_id), .cur_a(cur_a), .cur_b(cur_b)
    );

    demorgan_sweep_checker #(.WIDTH(1)) dut_w1 (
        .clk(clk), .reset(reset), .start(start_w1),
        .inject0(inject0_w1), .inject1(inject1_w1),
        .busy(busy_w1), .done(done_w1), .pass(pass_w1), .err_count(err_count_w1),
        .first_fail_a(first_fail_a_w1), .first_fail_b(first_fail_b_w1),
        .first_fail_id(first_fail_id_w1), .cur_a(cur_a_w1), .cur_b(cur_b_w1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=2 sweep (N=16): walk, drain, done at E0+17 and final results
    task automatic run_sweep(input string name, input logic [1:0] m0, input logic [1:0] m1,
                             input int exp_err, input logic [1:0] exp_a, input logic [1:0] exp_b,
                             input logic [1:0] exp_id, input bit mid_start, input bit mid_mask);
        logic [3:0] kv;
        @(negedge clk);
        start   = 1'b1;
        inject0 = m0;
        inject1 = m1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " start_done"}, 32'(done), 32'd0);
        check({name, " start_err"},  32'(err_count), 32'd0);
        check({name, " start_id"},   32'(first_fail_id), 32'd0);
        check({name, " start_pass"}, 32'(pass), 32'd0);
        for (int k = 0; k < 16; k++) begin
            kv = 4'(k);
            check({name, " cur_a"}, 32'(cur_a), 32'(kv[3:2]));
            check({name, " cur_b"}, 32'(cur_b), 32'(kv[1:0]));
            check({name, " run_busy"}, 32'(busy), 32'd1);
            check({name, " run_done"}, 32'(done), 32'd0);
            if (mid_start && k == 5) start = 1'b1;
            if (mid_mask && k == 3) begin
                inject0 = ~m0;
                inject1 = 2'b01;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({name, " drain_busy"}, 32'(busy), 32'd1);
        check({name, " drain_done"}, 32'(done), 32'd0);
        check({name, " drain_cur"},  32'({cur_a, cur_b}), 32'hF);
        @(posedge clk); #1;
        check({name, " fin_done"}, 32'(done), 32'd1);
        check({name, " fin_busy"}, 32'(busy), 32'd0);
        check({name, " fin_err"},  32'(err_count), 32'(exp_err));
        check({name, " fin_pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
        check({name, " fin_ffa"},  32'(first_fail_a), 32'(exp_a));
        check({name, " fin_ffb"},  32'(first_fail_b), 32'(exp_b));
        check({name, " fin_ffid"}, 32'(first_fail_id), 32'(exp_id));
        inject0 = 2'b00;
        inject1 = 2'b00;
    endtask

    initial begin
        // Power-on reset
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err_count), 32'd0);
        check("rst_ff",   32'({first_fail_a, first_fail_b, first_fail_id}), 32'd0);
        check("rst_cur",  32'({cur_a, cur_b}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Clean sweep, single identity-0 fault, both identities with mid-run mask change
        run_sweep("clean", 2'b00, 2'b00, 0,  2'd0, 2'd0, 2'b00, 1'b0, 1'b0);
        run_sweep("inj0",  2'b01, 2'b00, 16, 2'd0, 2'd0, 2'b01, 1'b0, 1'b0);
        run_sweep("both",  2'b10, 2'b10, 32, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1);
        // Restart straight from DONE, with an ignored start in RUN
        run_sweep("midst", 2'b00, 2'b00, 0,  2'd0, 2'd0, 2'b00, 1'b1, 1'b0);
        run_sweep("again", 2'b00, 2'b00, 0,  2'd0, 2'd0, 2'b00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a faulty sweep
        @(negedge clk);
        start   = 1'b1;
        inject0 = 2'b01;
        @(posedge clk); #1;
        start   = 1'b0;
        inject0 = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        check("pre_abort_err", 32'(err_count != 6'd0), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err",  32'(err_count), 32'd0);
        check("abort_ff",   32'({first_fail_a, first_fail_b, first_fail_id}), 32'd0);
        check("abort_cur",  32'({cur_a, cur_b}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'({busy, done}), 32'd0);
        run_sweep("post",  2'b00, 2'b00, 0,  2'd0, 2'd0, 2'b00, 1'b0, 1'b0);

        // WIDTH=1 instance: N=4, done at E0+5
        @(negedge clk);
        start_w1 = 1'b1;
        @(posedge clk); #1;
        start_w1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kv1;
            kv1 = 2'(k);
            check("w1_cur_a", 32'(cur_a_w1), 32'(kv1[1]));
            check("w1_cur_b", 32'(cur_b_w1), 32'(kv1[0]));
            check("w1_busy",  32'(busy_w1), 32'd1);
            @(posedge clk); #1;
        end
        check("w1_drain_done", 32'(done_w1), 32'd0);
        @(posedge clk); #1;
        check("w1_done", 32'(done_w1), 32'd1);
        check("w1_busy_low", 32'(busy_w1), 32'd0);
        check("w1_pass", 32'(pass_w1), 32'd1);
        check("w1_err",  32'(err_count_w1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
